// File: rtl/pipe_adder.sv
// pipe_adder: segmented, fully pipelined adder/subtractor.
// Each stage adds one SEG-bit slice and registers the carry for the next.
// The operand slices that are still to be added travel down the pipe with
// the transaction; finished result slices build up in a partial-sum word.
// A single advance enable stalls every stage while the output is held.
module pipe_adder #(
  parameter int WIDTH = 36,
  parameter int SEG   = 9
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             Ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int NSEG = WIDTH / SEG;

  // Signed overflow from the two operand sign bits and the result sign bit.
  function automatic logic ovf_f(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  // Values presented to each stage's adder this cycle.
  logic [WIDTH-1:0] cur_a_s   [NSEG];
  logic [WIDTH-1:0] cur_b_s   [NSEG];
  logic             cur_c_s   [NSEG];
  logic             cur_v_s   [NSEG];
  logic [WIDTH-1:0] cur_sum_s [NSEG];
  logic [SEG:0]     seg_s     [NSEG];
  logic [WIDTH-1:0] nxt_sum_s [NSEG];
  logic             en_s;

  // Inter-stage registers (stage 0 .. NSEG-2); the last stage feeds the outputs.
  // Operands are kept pre-shifted so the active slice is always in the low SEG bits.
  logic [WIDTH-1:0] a_r   [NSEG-1];
  logic [WIDTH-1:0] b_r   [NSEG-1];
  logic [WIDTH-1:0] sum_r [NSEG-1];
  logic             cy_r  [NSEG-1];
  logic             vld_r [NSEG-1];

  logic [WIDTH-1:0] s_r;
  logic             cout_r;
  logic             ovf_r;
  logic             out_valid_r;

  assign en_s      = !out_valid_r || out_ready;
  assign in_ready  = en_s;
  assign S         = s_r;
  assign Cout      = cout_r;
  assign Ovf       = ovf_r;
  assign out_valid = out_valid_r;

  // Route the port inputs to stage 0 and each register bank to the next stage.
  // Subtraction is folded in here: B is inverted and the initial carry forced to 1.
  always_comb begin
    cur_a_s[0]   = A;
    cur_v_s[0]   = in_valid;
    cur_sum_s[0] = {WIDTH{1'b0}};
    if (Sub) begin
      cur_b_s[0] = ~B;
      cur_c_s[0] = 1'b1;
    end else begin
      cur_b_s[0] = B;
      cur_c_s[0] = Cin;
    end
    for (int k = 1; k < NSEG; k++) begin
      cur_a_s[k]   = a_r[k-1];
      cur_b_s[k]   = b_r[k-1];
      cur_c_s[k]   = cy_r[k-1];
      cur_v_s[k]   = vld_r[k-1];
      cur_sum_s[k] = sum_r[k-1];
    end
  end

  // One SEG-bit ripple add per stage; the slice result is placed at its final bit position.
  always_comb begin
    for (int k = 0; k < NSEG; k++) begin
      seg_s[k]     = {1'b0, cur_a_s[k][SEG-1:0]}
                   + {1'b0, cur_b_s[k][SEG-1:0]}
                   + {{SEG{1'b0}}, cur_c_s[k]};
      nxt_sum_s[k] = cur_sum_s[k]
                   | ({{(WIDTH-SEG){1'b0}}, seg_s[k][SEG-1:0]} << (k * SEG));
    end
  end

  // Pipeline advance: everything moves together on en; data fields only load
  // for valid transactions so bubbles never disturb the held result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NSEG - 1; k++) begin
        vld_r[k] <= 1'b0;
        cy_r[k]  <= 1'b0;
        a_r[k]   <= {WIDTH{1'b0}};
        b_r[k]   <= {WIDTH{1'b0}};
        sum_r[k] <= {WIDTH{1'b0}};
      end
      out_valid_r <= 1'b0;
      s_r         <= {WIDTH{1'b0}};
      cout_r      <= 1'b0;
      ovf_r       <= 1'b0;
    end else if (en_s) begin
      for (int k = 0; k < NSEG - 1; k++) begin
        vld_r[k] <= cur_v_s[k];
        if (cur_v_s[k]) begin
          cy_r[k]  <= seg_s[k][SEG];
          a_r[k]   <= cur_a_s[k] >> SEG;
          b_r[k]   <= cur_b_s[k] >> SEG;
          sum_r[k] <= nxt_sum_s[k];
        end
      end
      out_valid_r <= cur_v_s[NSEG-1];
      if (cur_v_s[NSEG-1]) begin
        s_r    <= nxt_sum_s[NSEG-1];
        cout_r <= seg_s[NSEG-1][SEG];
        ovf_r  <= ovf_f(cur_a_s[NSEG-1][SEG-1], cur_b_s[NSEG-1][SEG-1],
                        nxt_sum_s[NSEG-1][WIDTH-1]);
      end
    end
  end

endmodule

// File: tb/tb_pipe_adder.sv
// Scoreboard bench for pipe_adder (36/9 instance plus a 16/4 instance).
module tb_pipe_adder;

  localparam int W   = 36;
  localparam int SG  = 9;
  localparam int NS  = W / SG;
  localparam int W2  = 16;
  localparam int SG2 = 4;
  localparam int NS2 = W2 / SG2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic [W-1:0]  a, b, s;
  logic          cin, sub, in_valid, in_ready, cout, ovf, out_valid, out_ready;
  logic [W2-1:0] a16, b16, s16;
  logic          cin16, sub16, in_valid16, in_ready16, cout16, ovf16, out_valid16, out_ready16;

  pipe_adder #(.WIDTH(W), .SEG(SG)) dut (
    .clk(clk), .reset_n(reset_n), .A(a), .B(b), .Cin(cin), .Sub(sub),
    .in_valid(in_valid), .in_ready(in_ready), .S(s), .Cout(cout), .Ovf(ovf),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  pipe_adder #(.WIDTH(W2), .SEG(SG2)) dut16 (
    .clk(clk), .reset_n(reset_n), .A(a16), .B(b16), .Cin(cin16), .Sub(sub16),
    .in_valid(in_valid16), .in_ready(in_ready16), .S(s16), .Cout(cout16), .Ovf(ovf16),
    .out_valid(out_valid16), .out_ready(out_ready16)
  );

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference: plain wide arithmetic for the sum, signed range test for overflow.
  function automatic exp_t model(input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                                 input logic cin_i, input logic sub_i);
    exp_t         e;
    logic [W:0]   full;
    logic [W-1:0] bx;
    logic         c0;
    longint       sa, sb, sr, maxv, minv;
    bx   = sub_i ? ~b_i : b_i;
    c0   = sub_i ? 1'b1 : cin_i;
    full = {1'b0, a_i} + {1'b0, bx} + {{W{1'b0}}, c0};
    sa   = $signed(a_i);
    sb   = $signed(bx);
    sr   = sa + sb + longint'(c0);
    maxv = (longint'(1) <<< (W - 1)) - 1;
    minv = -(longint'(1) <<< (W - 1));
    e.s  = full[W-1:0];
    e.c  = full[W];
    e.o  = (sr > maxv) || (sr < minv);
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Stimulus side of the scoreboard: record expected result at each input transfer.
  always @(negedge clk) begin
    if (reset_n && in_valid && in_ready)
      exp_q.push_back(model(a, b, cin, sub));
  end

  // Monitor: check handshake rule every cycle and each output transfer in order.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n) begin
      chk("in_ready_rule", 64'(in_ready), 64'(!out_valid || out_ready));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_out: got S=%0h with no transaction pending, required none", s);
        end else begin
          e = exp_q.pop_front();
          n_vec++;
          if ({s, cout, ovf} !== {e.s, e.c, e.o}) begin
            n_err++;
            $display("FAIL result: got S=%0h C=%0b O=%0b, required S=%0h C=%0b O=%0b",
                     s, cout, ovf, e.s, e.c, e.o);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  // Offer one transaction until accepted; optionally randomise out_ready each cycle.
  task automatic drive(input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                       input logic cin_i, input logic sub_i, input bit rnd);
    int guard;
    bit took;
    a = a_i; b = b_i; cin = cin_i; sub = sub_i; in_valid = 1'b1;
    guard = 0; took = 1'b0;
    while (!took && guard < 1000) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      took = in_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    if (!took) begin
      n_vec++;
      n_err++;
      $display("FAIL accept: got no input transfer in %0d cycles, required one", guard);
    end
  endtask

  // Single transaction into an empty pipe; check latency and the given result.
  task automatic directed(input string name, input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                          input logic cin_i, input logic sub_i,
                          input logic [W-1:0] es, input logic ec, input logic eo);
    int lat;
    out_ready = 1'b1;
    drive(a_i, b_i, cin_i, sub_i, 1'b0);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 4 * NS) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({name, "_latency"}, 64'(lat), 64'(NS));
    chk({name, "_S"}, 64'(s), 64'(es));
    chk({name, "_Cout"}, 64'(cout), 64'(ec));
    chk({name, "_Ovf"}, 64'(ovf), 64'(eo));
  endtask

  initial begin
    logic [63:0] r1, r2;
    int lat, seen, guard;

    reset_n = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a16 = '0; b16 = '0; cin16 = 1'b0; sub16 = 1'b0; in_valid16 = 1'b0; out_ready16 = 1'b1;
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_S", 64'(s), 64'd0);
    chk("reset_CoutOvf", 64'({cout, ovf}), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk);
    #1;

    directed("wrap",   36'h0_0000_0001, 36'hF_FFFF_FFFF, 1'b0, 1'b0, 36'h0_0000_0000, 1'b1, 1'b0);
    directed("negovf", 36'h8_0000_0000, 36'h8_0000_0000, 1'b1, 1'b0, 36'h0_0000_0001, 1'b1, 1'b1);
    directed("sub57",  36'd5, 36'd7, 1'b0, 1'b1, 36'hF_FFFF_FFFE, 1'b0, 1'b0);
    directed("sub75",  36'd7, 36'd5, 1'b1, 1'b1, 36'h0_0000_0002, 1'b1, 1'b0);
    directed("chain",  36'h7_FFFF_FFFF, 36'd0, 1'b1, 1'b0, 36'h8_0000_0000, 1'b0, 1'b1);

    // Back-to-back stream with random backpressure.
    for (int i = 0; i < 4096; i++) begin
      drive({W{1'b0}}, W'(i), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
      drive(W'(i), W'(i + 1), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
    end
    // Random operands with bubbles.
    for (int j = 0; j < 400; j++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        out_ready = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
      end
      r1 = {$urandom(), $urandom()};
      r2 = {$urandom(), $urandom()};
      drive(r1[W-1:0], r2[W-1:0], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    chk("drain_pending", 64'(exp_q.size()), 64'd0);

    // Reset with results in flight and one held at the stalled output.
    drive(36'h1_2345_6789, 36'h0_0000_1111, 1'b0, 1'b0, 1'b0);
    drive(36'h0_FFFF_0000, 36'h0_0001_0000, 1'b1, 1'b0, 1'b0);
    drive(36'h3_0000_0003, 36'h0_0000_0001, 1'b0, 1'b1, 1'b0);
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("prereset_out_valid", 64'(out_valid), 64'd1);
    #2;
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    chk("midreset_out_valid", 64'(out_valid), 64'd0);
    chk("midreset_S", 64'(s), 64'd0);
    chk("midreset_CoutOvf", 64'({cout, ovf}), 64'd0);
    chk("midreset_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    repeat (NS + 3) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    chk("stale_outputs", 64'(seen), 64'd0);
    directed("postreset", 36'd5, 36'd7, 1'b0, 1'b1, 36'hF_FFFF_FFFE, 1'b0, 1'b0);
    @(posedge clk);
    #1;

    // Narrow instance: carry across every slice boundary and latency.
    a16 = 16'h7FFF; b16 = 16'h0000; cin16 = 1'b1; sub16 = 1'b0; in_valid16 = 1'b1;
    @(posedge clk);
    #1;
    in_valid16 = 1'b0;
    lat = 1;
    while (!out_valid16 && lat < 4 * NS2) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("w16_latency", 64'(lat), 64'(NS2));
    chk("w16_S", 64'(s16), 64'h8000);
    chk("w16_CoutOvf", 64'({cout16, ovf16}), 64'b01);

    // Narrow instance: reset mid-flight.
    for (int k = 0; k < 3; k++) begin
      a16 = 16'(k + 16'h0100); b16 = 16'h0011; in_valid16 = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid16 = 1'b0;
    out_ready16 = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("w16_prereset_valid", 64'(out_valid16), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("w16_midreset_valid", 64'(out_valid16), 64'd0);
    chk("w16_midreset_S", 64'(s16), 64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    out_ready16 = 1'b1;
    seen = 0;
    repeat (NS2 + 3) begin
      @(posedge clk);
      #1;
      if (out_valid16) seen++;
    end
    chk("w16_stale_outputs", 64'(seen), 64'd0);
    a16 = 16'd7; b16 = 16'd5; cin16 = 1'b0; sub16 = 1'b1; in_valid16 = 1'b1;
    @(posedge clk);
    #1;
    in_valid16 = 1'b0;
    lat = 1;
    while (!out_valid16 && lat < 4 * NS2) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("w16_post_latency", 64'(lat), 64'(NS2));
    chk("w16_post_S", 64'(s16), 64'h0002);
    chk("w16_post_CoutOvf", 64'({cout16, ovf16}), 64'b10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
